// File: rtl/ro_buffer.sv
// ro_buffer: in-order retirement buffer that tags issued instructions, captures rss/lsb results,
// and retires them in program order, flushing the core on a mispredicted branch.
module ro_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ID_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                issue_valid,
    input  logic [1:0]          issue_kind,
    input  logic [4:0]          issue_rd,
    input  logic [31:0]         issue_pred_pc,
    output logic [ID_WIDTH-1:0] issue_id,
    output logic                is_ro_buffer_full,
    input  logic [ID_WIDTH-1:0] dest_from_rss_bus,
    input  logic [31:0]         value_from_rss_bus,
    input  logic [31:0]         next_pc_from_rss_bus,
    input  logic [ID_WIDTH-1:0] dest_from_lsb_bus,
    input  logic [31:0]         value_from_lsb_bus,
    input  logic [ID_WIDTH-1:0] query_id,
    output logic                query_ready,
    output logic [31:0]         query_value,
    output logic [ID_WIDTH-1:0] commit_dest,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_value,
    output logic [ID_WIDTH-1:0] store_commit_id,
    output logic                reset_to_rob_bus,
    output logic [31:0]         pc_to_fetcher
);
    localparam int IW = $clog2(ROB_SIZE);

    logic [IW-1:0]       head, tail, wr_idx, wl_idx, q_idx;
    logic [ID_WIDTH-1:0] count, head_id;
    logic [ROB_SIZE-1:0] busy, ready;
    logic [1:0]          kind      [ROB_SIZE];
    logic [4:0]          rd_q      [ROB_SIZE];
    logic [31:0]         value_q   [ROB_SIZE];
    logic [31:0]         pred_pc   [ROB_SIZE];
    logic [31:0]         actual_pc [ROB_SIZE];
    logic                commit, mispredict, alloc, wb_rss, wb_lsb, stored_hit;

    function automatic logic tag_ok(input logic [ID_WIDTH-1:0] t);
        return t != '0 && t <= ID_WIDTH'(ROB_SIZE);
    endfunction

    function automatic logic [IW-1:0] idx(input logic [ID_WIDTH-1:0] t);
        return IW'(t - ID_WIDTH'(1));
    endfunction

    assign wr_idx            = idx(dest_from_rss_bus);
    assign wl_idx            = idx(dest_from_lsb_bus);
    assign q_idx             = idx(query_id);
    assign head_id           = ID_WIDTH'(head) + ID_WIDTH'(1);
    assign issue_id          = ID_WIDTH'(tail) + ID_WIDTH'(1);
    assign is_ro_buffer_full = count >= ID_WIDTH'(ROB_SIZE - 1);
    assign commit            = rdy && busy[head] && ready[head];
    assign mispredict        = commit && kind[head] == 2'd1 && actual_pc[head] != pred_pc[head];
    // A full buffer still accepts an issue in the cycle its head retires.
    assign alloc  = rdy && issue_valid && !reset_to_rob_bus && !mispredict &&
                    (count < ID_WIDTH'(ROB_SIZE) || commit);
    assign wb_rss = rdy && !reset_to_rob_bus && tag_ok(dest_from_rss_bus) && busy[wr_idx];
    assign wb_lsb = rdy && !reset_to_rob_bus && tag_ok(dest_from_lsb_bus) && busy[wl_idx];

    assign stored_hit  = tag_ok(query_id) && busy[q_idx] && ready[q_idx];
    assign query_ready = query_id == '0 || stored_hit || query_id == dest_from_rss_bus ||
                         query_id == dest_from_lsb_bus;
    assign query_value = query_id == '0               ? 32'd0 :
                         stored_hit                   ? value_q[q_idx] :
                         query_id == dest_from_rss_bus ? value_from_rss_bus :
                         query_id == dest_from_lsb_bus ? value_from_lsb_bus : 32'd0;

    always_ff @(posedge clk) begin
        if (wb_rss) begin
            value_q[wr_idx]   <= value_from_rss_bus;
            actual_pc[wr_idx] <= next_pc_from_rss_bus;
        end
        if (wb_lsb) value_q[wl_idx] <= value_from_lsb_bus;
        if (alloc) begin
            kind[tail]    <= issue_kind;
            rd_q[tail]    <= issue_rd;
            pred_pc[tail] <= issue_pred_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            busy             <= '0;
            ready            <= '0;
            commit_dest      <= '0;
            commit_rd        <= '0;
            commit_value     <= '0;
            store_commit_id  <= '0;
            reset_to_rob_bus <= 1'b0;
            pc_to_fetcher    <= '0;
        end else if (rdy) begin
            commit_dest      <= '0;
            commit_rd        <= '0;
            commit_value     <= '0;
            store_commit_id  <= '0;
            reset_to_rob_bus <= 1'b0;
            pc_to_fetcher    <= '0;
            if (wb_rss) ready[wr_idx] <= 1'b1;
            if (wb_lsb) ready[wl_idx] <= 1'b1;
            if (commit) begin
                busy[head]  <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head + IW'(1);
                if (kind[head] == 2'd2) begin
                    store_commit_id <= head_id;
                end else begin
                    commit_dest  <= head_id;
                    commit_rd    <= rd_q[head];
                    commit_value <= value_q[head];
                end
            end
            // Allocation follows commit so a slot freed and reused in one cycle ends up busy.
            if (alloc) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= issue_kind == 2'd2;
                tail        <= tail + IW'(1);
            end
            count <= count + ID_WIDTH'(alloc) - ID_WIDTH'(commit);
            if (mispredict) begin
                head             <= '0;
                tail             <= '0;
                count            <= '0;
                busy             <= '0;
                ready            <= '0;
                reset_to_rob_bus <= 1'b1;
                pc_to_fetcher    <= actual_pc[head];
            end
        end
    end
endmodule

// File: tb/tb_ro_buffer.sv
// tb_ro_buffer: directed-vector bench for ro_buffer with hand-computed expectations.
module tb_ro_buffer;
    logic        clk = 1'b0;
    logic        rst, rdy, issue_valid;
    logic [1:0]  issue_kind;
    logic [4:0]  issue_rd, commit_rd;
    logic [31:0] issue_pred_pc, value_from_rss_bus, next_pc_from_rss_bus, value_from_lsb_bus;
    logic [31:0] query_value, commit_value, pc_to_fetcher;
    logic [4:0]  issue_id, dest_from_rss_bus, dest_from_lsb_bus, query_id, commit_dest, store_commit_id;
    logic        is_ro_buffer_full, query_ready, reset_to_rob_bus;
    int          n_checks = 0;
    int          n_fail = 0;

    ro_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_kind(issue_kind), .issue_rd(issue_rd),
        .issue_pred_pc(issue_pred_pc), .issue_id(issue_id), .is_ro_buffer_full(is_ro_buffer_full),
        .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
        .next_pc_from_rss_bus(next_pc_from_rss_bus), .dest_from_lsb_bus(dest_from_lsb_bus),
        .value_from_lsb_bus(value_from_lsb_bus), .query_id(query_id), .query_ready(query_ready),
        .query_value(query_value), .commit_dest(commit_dest), .commit_rd(commit_rd),
        .commit_value(commit_value), .store_commit_id(store_commit_id),
        .reset_to_rob_bus(reset_to_rob_bus), .pc_to_fetcher(pc_to_fetcher)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_kind = 2'd0; issue_rd = 5'd0; issue_pred_pc = 32'd0;
        dest_from_rss_bus = 5'd0; value_from_rss_bus = 32'd0; next_pc_from_rss_bus = 32'd0;
        dest_from_lsb_bus = 5'd0; value_from_lsb_bus = 32'd0; query_id = 5'd0;
    endtask

    task automatic issue(input logic [1:0] k, input logic [4:0] r, input logic [31:0] pc);
        issue_valid = 1'b1; issue_kind = k; issue_rd = r; issue_pred_pc = pc;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        rdy = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("reset issue_id", 32'(issue_id), 32'd1);
        chk("reset full", 32'(is_ro_buffer_full), 32'd0);
        chk("reset commit_dest", 32'(commit_dest), 32'd0);
        chk("reset flush", 32'(reset_to_rob_bus), 32'd0);
        chk("query id0 ready", 32'(query_ready), 32'd1);
        chk("query id0 value", query_value, 32'd0);

        issue(2'd0, 5'd1, 32'd0);
        issue(2'd0, 5'd2, 32'd0);
        issue(2'd0, 5'd3, 32'd0);
        chk("three issued id", 32'(issue_id), 32'd4);
        dest_from_rss_bus = 5'd3; value_from_rss_bus = 32'd30;
        dest_from_lsb_bus = 5'd1; value_from_lsb_bus = 32'd10;
        query_id = 5'd3;
        #1 chk("query rss bypass", query_value, 32'd30);
        query_id = 5'd1;
        #1 chk("query lsb bypass", query_value, 32'd10);
        query_id = 5'd2;
        #1 chk("query not ready", 32'(query_ready), 32'd0);
        tick();
        idle();
        query_id = 5'd3;
        #1 chk("query stored", query_value, 32'd30);
        chk("no early commit", 32'(commit_dest), 32'd0);
        dest_from_rss_bus = 5'd2; value_from_rss_bus = 32'd20;
        tick();
        idle();
        chk("c1 dest", 32'(commit_dest), 32'd1);
        chk("c1 rd", 32'(commit_rd), 32'd1);
        chk("c1 value", commit_value, 32'd10);
        tick();
        chk("c2 dest", 32'(commit_dest), 32'd2);
        chk("c2 value", commit_value, 32'd20);
        tick();
        chk("c3 dest", 32'(commit_dest), 32'd3);
        chk("c3 rd", 32'(commit_rd), 32'd3);
        chk("c3 value", commit_value, 32'd30);
        tick();
        chk("commit pulse ends", 32'(commit_dest), 32'd0);

        for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 4), 32'd0);
        chk("five live id", 32'(issue_id), 32'd9);
        dest_from_rss_bus = 5'd4; value_from_rss_bus = 32'h44;
        tick();
        idle();
        tick();
        chk("pre-reset commit", 32'(commit_dest), 32'd4);
        rst = 1'b0;
        #2 chk("async reset commit", 32'(commit_dest), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid reset issue_id", 32'(issue_id), 32'd1);
        chk("mid reset full", 32'(is_ro_buffer_full), 32'd0);
        chk("mid reset commit_value", commit_value, 32'd0);

        issue(2'd1, 5'd7, 32'h100);
        dest_from_rss_bus = 5'd1; value_from_rss_bus = 32'h99; next_pc_from_rss_bus = 32'h104;
        issue(2'd0, 5'd8, 32'd0);
        idle();
        chk("pre-flush issue_id", 32'(issue_id), 32'd3);
        issue_valid = 1'b1;
        tick();
        chk("flush pulse", 32'(reset_to_rob_bus), 32'd1);
        chk("flush pc", pc_to_fetcher, 32'h104);
        chk("flush link dest", 32'(commit_dest), 32'd1);
        chk("flush link rd", 32'(commit_rd), 32'd7);
        chk("flush link value", commit_value, 32'h99);
        chk("flush issue_id", 32'(issue_id), 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("flush ends", 32'(reset_to_rob_bus), 32'd0);
        chk("flush pc clear", pc_to_fetcher, 32'd0);
        chk("issue ignored in flush", 32'(issue_id), 32'd1);

        issue(2'd1, 5'd0, 32'h200);
        dest_from_rss_bus = 5'd1; value_from_rss_bus = 32'h11; next_pc_from_rss_bus = 32'h200;
        tick();
        idle();
        tick();
        chk("good branch dest", 32'(commit_dest), 32'd1);
        chk("good branch no flush", 32'(reset_to_rob_bus), 32'd0);

        for (int i = 0; i < 14; i++) issue(2'd0, 5'd1, 32'd0);
        chk("14 not full", 32'(is_ro_buffer_full), 32'd0);
        issue(2'd0, 5'd1, 32'd0);
        chk("15 full", 32'(is_ro_buffer_full), 32'd1);
        issue(2'd0, 5'd1, 32'd0);
        chk("16th accepted", 32'(issue_id), 32'd2);
        issue(2'd0, 5'd1, 32'd0);
        chk("17th dropped", 32'(issue_id), 32'd2);
        dest_from_rss_bus = 5'd4; value_from_rss_bus = 32'h55; query_id = 5'd4;
        #1 chk("query 4 ready", 32'(query_ready), 32'd1);
        chk("query 4 value", query_value, 32'h55);
        tick();
        idle();
        dest_from_lsb_bus = 5'd2; value_from_lsb_bus = 32'h22;
        tick();
        idle();
        issue(2'd0, 5'd6, 32'd0);
        chk("full commit dest", 32'(commit_dest), 32'd2);
        chk("full commit value", commit_value, 32'h22);
        chk("alloc on commit", 32'(issue_id), 32'd3);
        issue(2'd0, 5'd6, 32'd0);
        chk("still full dropped", 32'(issue_id), 32'd3);
        chk("still full flag", 32'(is_ro_buffer_full), 32'd1);

        do_reset();
        issue(2'd0, 5'd9, 32'd0);
        issue(2'd2, 5'd0, 32'd0);
        dest_from_lsb_bus = 5'd1; value_from_lsb_bus = 32'h77;
        tick();
        idle();
        tick();
        chk("reg before store", 32'(commit_dest), 32'd1);
        chk("store not yet", 32'(store_commit_id), 32'd0);
        tick();
        chk("store commit", 32'(store_commit_id), 32'd2);
        chk("store no reg write", 32'(commit_dest), 32'd0);
        rdy = 1'b0;
        tick();
        tick();
        chk("rdy low holds store", 32'(store_commit_id), 32'd2);
        rdy = 1'b1;
        tick();
        chk("store pulse ends", 32'(store_commit_id), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
